// File: rtl/fdct_block_encoder_pkg.sv
// Shared types and constants for the forward-DCT block encoder.
// FSM encoding, the integer C matrix (scale 4096), scale shifts, strides.
package fdct_block_encoder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_PASS_T,
    ST_PASS_S,
    ST_WRITE
  } fdct_state_e;

  localparam logic [17:0] PIXEL_STRIDE_DEF = 18'd160;
  localparam logic [17:0] COEFF_STRIDE_DEF = 18'd320;

  localparam int T_SHIFT = 8;
  localparam int S_SHIFT = 16;

  // Row k is DCT basis k sampled at j = 0..7; shared with the decoder.
  localparam logic [0:63][11:0] C_TAB = {
    12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,
    12'sd1448,  12'sd1448,  12'sd1448,  12'sd1448,
    12'sd2008,  12'sd1702,  12'sd1137,  12'sd399,
    -12'sd399,  -12'sd1137, -12'sd1702, -12'sd2008,
    12'sd1892,  12'sd783,   -12'sd783,  -12'sd1892,
    -12'sd1892, -12'sd783,  12'sd783,   12'sd1892,
    12'sd1702,  -12'sd399,  -12'sd2008, -12'sd1137,
    12'sd1137,  12'sd2008,  12'sd399,   -12'sd1702,
    12'sd1448,  -12'sd1448, -12'sd1448, 12'sd1448,
    12'sd1448,  -12'sd1448, -12'sd1448, 12'sd1448,
    12'sd1137,  -12'sd2008, 12'sd399,   12'sd1702,
    -12'sd1702, -12'sd399,  12'sd2008,  -12'sd1137,
    12'sd783,   -12'sd1892, 12'sd1892,  -12'sd783,
    -12'sd783,  12'sd1892,  -12'sd1892, 12'sd783,
    12'sd399,   -12'sd1137, 12'sd1702,  -12'sd2008,
    12'sd2008,  -12'sd1702, 12'sd1137,  -12'sd399
  };

  function automatic logic signed [11:0] c_lookup(
    input logic [2:0] k,
    input logic [2:0] j
  );
    return $signed(C_TAB[{k, j}]);
  endfunction

endpackage

// File: rtl/fdct_block_encoder_if.sv
// Sequencer handshake and SRAM port of the forward-DCT block encoder.
// master: sequencer/SRAM side; slave: the encoder.
interface fdct_block_encoder_if;

  logic        Start;
  logic [17:0] Pixel_address;
  logic [17:0] Coeff_address;
  logic        Busy;
  logic        Done;
  logic [17:0] SRAM_address;
  logic [15:0] SRAM_read_data;
  logic [15:0] SRAM_write_data;
  logic        SRAM_we_n;

  modport master (
    output Start,
    output Pixel_address,
    output Coeff_address,
    output SRAM_read_data,
    input  Busy,
    input  Done,
    input  SRAM_address,
    input  SRAM_write_data,
    input  SRAM_we_n
  );

  modport slave (
    input  Start,
    input  Pixel_address,
    input  Coeff_address,
    input  SRAM_read_data,
    output Busy,
    output Done,
    output SRAM_address,
    output SRAM_write_data,
    output SRAM_we_n
  );

endinterface

// File: rtl/fdct_block_encoder_c_rom.sv
// Two-port C-matrix lookup: (row, col) -> signed coefficient.
// Both multipliers read through this one table.
module fdct_c_rom
  import fdct_block_encoder_pkg::*;
(
  input  logic [2:0]         row0,
  input  logic [2:0]         col0,
  input  logic [2:0]         row1,
  input  logic [2:0]         col1,
  output logic signed [11:0] c0,
  output logic signed [11:0] c1
);

  assign c0 = c_lookup(row0, col0);
  assign c1 = c_lookup(row1, col1);

endmodule

// File: rtl/fdct_block_encoder.sv
// 8x8 forward DCT S = C*P*C^T: fetch, row pass, column pass, write.
// Build option FDCT_LEVEL_SHIFT_EN: pixels become signed (P - 128).
module fdct_block_encoder
  import fdct_block_encoder_pkg::*;
#(
  parameter logic [17:0] PIXEL_STRIDE = PIXEL_STRIDE_DEF,
  parameter logic [17:0] COEFF_STRIDE = COEFF_STRIDE_DEF
) (
  input logic                 Clock,
  input logic                 Resetn,
  fdct_block_encoder_if.slave bus
);

  fdct_state_e state_q;
  fdct_state_e state_d;

  logic [7:0]  cnt_q;
  logic [17:0] pix_base_q;
  logic [17:0] coeff_base_q;

  logic [17:0] addr_q;
  logic [17:0] addr_d;
  logic [15:0] wdata_q;
  logic [15:0] wdata_d;
  logic        we_n_q;
  logic        we_n_d;
  logic        busy_q;
  logic        busy_d;
  logic        done_q;
  logic        done_d;

  logic [7:0]  pix_arr [64];
  logic [15:0] t_arr [64];
  logic [15:0] s_arr [64];

  logic [5:0]  ent;
  logic [1:0]  ph;
  logic [4:0]  fidx;
  logic [2:0]  c_row;

  logic signed [11:0] c0;
  logic signed [11:0] c1;
  logic signed [15:0] op0;
  logic signed [15:0] op1;
  logic signed [31:0] prod0;
  logic signed [31:0] prod1;
  logic signed [31:0] acc_q;
  logic signed [31:0] acc_sum;

  function automatic logic signed [15:0] pix_ext(input logic [7:0] p);
`ifdef FDCT_LEVEL_SHIFT_EN
    return {{8{~p[7]}}, ~p[7], p[6:0]};
`else
    return {8'b0, p};
`endif
  endfunction

  assign ent  = cnt_q[7:2];
  assign ph   = cnt_q[1:0];
  assign fidx = 5'(cnt_q - 8'd2);

  // Row pass walks k in the low entry bits; column pass walks k in the high.
  assign c_row = (state_q == ST_PASS_T) ? ent[2:0] : ent[5:3];

  fdct_c_rom u_rom (
    .row0 (c_row),
    .col0 ({ph, 1'b0}),
    .row1 (c_row),
    .col1 ({ph, 1'b1}),
    .c0   (c0),
    .c1   (c1)
  );

  // Operand select: pixels feed the row pass, T entries the column pass.
  always_comb begin
    if (state_q == ST_PASS_T) begin
      op0 = pix_ext(pix_arr[{ent[5:3], ph, 1'b0}]);
      op1 = pix_ext(pix_arr[{ent[5:3], ph, 1'b1}]);
    end else begin
      op0 = $signed(t_arr[{ph, 1'b0, ent[2:0]}]);
      op1 = $signed(t_arr[{ph, 1'b1, ent[2:0]}]);
    end
  end

  assign prod0   = 32'(op0) * 32'(c0);
  assign prod1   = 32'(op1) * 32'(c1);
  assign acc_sum = ((ph == 2'd0) ? 32'sd0 : acc_q) + prod0 + prod1;

  // State register.
  always_ff @(posedge Clock) begin
    if (!Resetn) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state: fixed-length phases, Start only honoured in IDLE.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (bus.Start)        state_d = ST_FETCH;
      ST_FETCH:  if (cnt_q == 8'd33)   state_d = ST_PASS_T;
      ST_PASS_T: if (cnt_q == 8'd255)  state_d = ST_PASS_S;
      ST_PASS_S: if (cnt_q == 8'd255)  state_d = ST_WRITE;
      ST_WRITE:  if (cnt_q == 8'd64)   state_d = ST_IDLE;
      default:                         state_d = ST_IDLE;
    endcase
  end

  // Next values of the registered SRAM/handshake outputs.
  always_comb begin
    addr_d  = addr_q;
    wdata_d = wdata_q;
    we_n_d  = 1'b1;
    busy_d  = (state_d != ST_IDLE);
    done_d  = 1'b0;
    unique case (state_q)
      ST_FETCH: begin
        if (cnt_q < 8'd32)
          addr_d = pix_base_q
                 + 18'(cnt_q[4:2]) * PIXEL_STRIDE
                 + 18'(cnt_q[1:0]);
      end
      ST_WRITE: begin
        if (cnt_q[6]) begin
          done_d = 1'b1;
        end else begin
          addr_d  = coeff_base_q
                  + 18'(cnt_q[5:3]) * COEFF_STRIDE
                  + 18'(cnt_q[2:0]);
          wdata_d = s_arr[cnt_q[5:0]];
          we_n_d  = 1'b0;
        end
      end
      default: ;
    endcase
  end

  // Output registers, phase counter and latched block addresses.
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      addr_q       <= '0;
      wdata_q      <= '0;
      we_n_q       <= 1'b1;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      cnt_q        <= '0;
      pix_base_q   <= '0;
      coeff_base_q <= '0;
    end else begin
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_n_q  <= we_n_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      if (state_d != state_q || state_q == ST_IDLE) cnt_q <= '0;
      else                                          cnt_q <= cnt_q + 8'd1;
      if (state_q == ST_IDLE && bus.Start) begin
        pix_base_q   <= bus.Pixel_address;
        coeff_base_q <= bus.Coeff_address;
      end
    end
  end

  // Datapath storage: pixel capture, MAC accumulator, T and S arrays.
  always_ff @(posedge Clock) begin
    if (state_q == ST_PASS_T || state_q == ST_PASS_S)
      acc_q <= acc_sum;
    if (state_q == ST_FETCH && cnt_q >= 8'd2) begin
      pix_arr[{fidx, 1'b0}] <= bus.SRAM_read_data[15:8];
      pix_arr[{fidx, 1'b1}] <= bus.SRAM_read_data[7:0];
    end
    if (state_q == ST_PASS_T && ph == 2'd3)
      t_arr[ent] <= acc_sum[T_SHIFT+15:T_SHIFT];
    if (state_q == ST_PASS_S && ph == 2'd3)
      s_arr[ent] <= acc_sum[S_SHIFT+15:S_SHIFT];
  end

  assign bus.SRAM_address    = addr_q;
  assign bus.SRAM_write_data = wdata_q;
  assign bus.SRAM_we_n       = we_n_q;
  assign bus.Busy            = busy_q;
  assign bus.Done            = done_q;

endmodule

// File: tb/tb_fdct_block_encoder.sv
// Self-checking bench for fdct_block_encoder.
// Reference DCT model fills a write scoreboard; SRAM modelled in the bench.
module tb_fdct_block_encoder;

  typedef struct packed {
    logic [17:0] a;
    logic [15:0] d;
  } wr_t;

  localparam logic [17:0] PS = 18'd160;
  localparam logic [17:0] CS = 18'd320;

  logic clk  = 1'b0;
  logic rstn = 1'b0;

  int n_cmp = 0;
  int n_bad = 0;

  logic [15:0] pmem [262144];
  logic [15:0] rd_q;
  int          blk [64];
  logic [15:0] exp_s [64];
  logic [15:0] got_s [64];
  wr_t         exp_q [$];
  int          rd_n;
  int          wr_n;
  int          dn_n;

  int cm [8][8] = '{
    '{1448, 1448, 1448, 1448, 1448, 1448, 1448, 1448},
    '{2008, 1702, 1137, 399, -399, -1137, -1702, -2008},
    '{1892, 783, -783, -1892, -1892, -783, 783, 1892},
    '{1702, -399, -2008, -1137, 1137, 2008, 399, -1702},
    '{1448, -1448, -1448, 1448, 1448, -1448, -1448, 1448},
    '{1137, -2008, 399, 1702, -1702, -399, 2008, -1137},
    '{783, -1892, 1892, -783, -783, 1892, -1892, 783},
    '{399, -1137, 1702, -2008, 2008, -1702, 1137, -399}
  };

  always #5 clk = ~clk;

  fdct_block_encoder_if bus ();

  fdct_block_encoder dut (
    .Clock  (clk),
    .Resetn (rstn),
    .bus    (bus)
  );

  always @(posedge clk) rd_q <= pmem[bus.SRAM_address];
  assign bus.SRAM_read_data = rd_q;

  task automatic clear_mem();
    for (int i = 0; i < 262144; i++) pmem[i] = 16'h0000;
  endtask

  task automatic compute();
    shortint tt [64];
    int acc;
    int pv;
    for (int r = 0; r < 8; r++)
      for (int k = 0; k < 8; k++) begin
        acc = 0;
        for (int j = 0; j < 8; j++) begin
          pv = blk[r*8+j];
`ifdef FDCT_LEVEL_SHIFT_EN
          pv = pv - 128;
`endif
          acc += pv * cm[k][j];
        end
        tt[r*8+k] = shortint'(acc >>> 8);
      end
    for (int k = 0; k < 8; k++)
      for (int m = 0; m < 8; m++) begin
        acc = 0;
        for (int r = 0; r < 8; r++)
          acc += cm[k][r] * int'(tt[r*8+m]);
        exp_s[k*8+m] = 16'(acc >>> 16);
      end
  endtask

  task automatic load_blk(input logic [17:0] pb);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 4; c++)
        pmem[pb + 18'(r) * PS + 18'(c)] =
          {8'(blk[r*8+2*c]), 8'(blk[r*8+2*c+1])};
  endtask

  task automatic run_block(
    input logic [17:0] pb,
    input logic [17:0] cb,
    input bit          restart,
    input int          last
  );
    wr_t         w;
    int          seq_err;
    int          first_bad;
    logic [17:0] prev;
    logic [17:0] ea;
    logic        eb;
    logic        ed;
    logic        ew;
    compute();
    load_blk(pb);
    for (int i = 0; i < 64; i++) begin
      w.a = cb + 18'(i / 8) * CS + 18'(i % 8);
      w.d = exp_s[i];
      exp_q.push_back(w);
    end
    seq_err   = 0;
    first_bad = -1;
    rd_n      = 0;
    wr_n      = 0;
    dn_n      = 0;
    prev      = bus.SRAM_address;
    bus.Pixel_address = pb;
    bus.Coeff_address = cb;
    bus.Start = 1'b1;
    for (int n = 0; n <= last; n++) begin
      @(negedge clk);
      bus.Start = restart && (n == 4 || n == 299);
      eb = (n < 611);
      ed = (n == 611);
      ew = !(n >= 547 && n <= 610);
      if (bus.Busy !== eb || bus.Done !== ed || bus.SRAM_we_n !== ew) begin
        if (first_bad < 0) first_bad = n;
        seq_err++;
      end
      if (n >= 1 && n <= 32) begin
        ea = pb + 18'((n - 1) / 4) * PS + 18'((n - 1) % 4);
        if (bus.SRAM_address !== ea) begin
          if (first_bad < 0) first_bad = n;
          seq_err++;
        end
      end
      if (bus.Done === 1'b1) dn_n++;
      if (bus.Busy === 1'b1 && bus.SRAM_we_n === 1'b1 &&
          bus.SRAM_address !== prev) rd_n++;
      if (bus.SRAM_we_n === 1'b0) begin
        if (wr_n < 64) got_s[wr_n] = bus.SRAM_write_data;
        wr_n++;
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_bad++;
          $display("FAIL wr_extra: addr=%h data=%h, required no write",
                   bus.SRAM_address, bus.SRAM_write_data);
        end else begin
          w = exp_q.pop_front();
          if (bus.SRAM_address !== w.a || bus.SRAM_write_data !== w.d) begin
            n_bad++;
            $display("FAIL wr_%0d: addr=%h data=%h, required addr=%h data=%h",
                     wr_n - 1, bus.SRAM_address, bus.SRAM_write_data,
                     w.a, w.d);
          end
        end
      end
      prev = bus.SRAM_address;
    end
    n_cmp++;
    if (seq_err !== 0) begin
      n_bad++;
      $display("FAIL seq_timing: %0d deviating cycles (first %0d), required 0",
               seq_err, first_bad);
    end
    n_cmp++;
    if (exp_q.size() !== 0) begin
      n_bad++;
      $display("FAIL wr_missing: %0d writes outstanding, required 0",
               exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if (bus.SRAM_address !== 18'd0) begin
      n_bad++;
      $display("FAIL rst_addr: got %h, required 0", bus.SRAM_address);
    end
    n_cmp++;
    if (bus.SRAM_write_data !== 16'd0) begin
      n_bad++;
      $display("FAIL rst_wdata: got %h, required 0", bus.SRAM_write_data);
    end
    n_cmp++;
    if (bus.SRAM_we_n !== 1'b1) begin
      n_bad++;
      $display("FAIL rst_we_n: got %b, required 1", bus.SRAM_we_n);
    end
    n_cmp++;
    if (bus.Busy !== 1'b0 || bus.Done !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_busy_done: got %b%b, required 00",
               bus.Busy, bus.Done);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic check_counts(input string tag);
    n_cmp++;
    if (rd_n !== 32) begin
      n_bad++;
      $display("FAIL %s_reads: got %0d, required 32", tag, rd_n);
    end
    n_cmp++;
    if (wr_n !== 64) begin
      n_bad++;
      $display("FAIL %s_writes: got %0d, required 64", tag, wr_n);
    end
    n_cmp++;
    if (dn_n !== 1) begin
      n_bad++;
      $display("FAIL %s_dones: got %0d, required 1", tag, dn_n);
    end
  endtask

  task automatic test_zero();
    int nz;
    for (int i = 0; i < 64; i++) blk[i] = 0;
    run_block(18'h00400, 18'h10000, 1'b0, 640);
    check_counts("zero");
    nz = 0;
    for (int i = 0; i < 64; i++) if (got_s[i] !== 16'h0000) nz++;
    n_cmp++;
    if (nz !== 0) begin
      n_bad++;
      $display("FAIL zero_coeffs: %0d nonzero, required 0", nz);
    end
  endtask

  task automatic test_const128();
    int nz;
    logic [15:0] e00;
    for (int i = 0; i < 64; i++) blk[i] = 128;
`ifdef FDCT_LEVEL_SHIFT_EN
    e00 = 16'd0;
`else
    e00 = 16'd1023;
`endif
    run_block(18'h01400, 18'h12000, 1'b0, 640);
    n_cmp++;
    if (got_s[0] !== e00) begin
      n_bad++;
      $display("FAIL c128_dc: got %0d, required %0d", got_s[0], e00);
    end
    nz = 0;
    for (int i = 1; i < 64; i++) if (got_s[i] !== 16'h0000) nz++;
    n_cmp++;
    if (nz !== 0) begin
      n_bad++;
      $display("FAIL c128_ac: %0d nonzero, required 0", nz);
    end
  endtask

  task automatic test_impulse();
    for (int i = 0; i < 64; i++) blk[i] = 0;
    blk[0] = 255;
    run_block(18'h02400, 18'h14000, 1'b0, 640);
`ifndef FDCT_LEVEL_SHIFT_EN
    n_cmp++;
    if (got_s[0] !== 16'd31) begin
      n_bad++;
      $display("FAIL imp_dc: got %0d, required 31", got_s[0]);
    end
`endif
    check_counts("imp");
  endtask

  task automatic test_restart();
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 255));
    run_block(18'h03400, 18'h16000, 1'b1, 640);
    check_counts("restart");
  endtask

  task automatic test_reset_mid();
    int bad;
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 255));
    load_blk(18'h04400);
    bus.Pixel_address = 18'h04400;
    bus.Coeff_address = 18'h18000;
    bus.Start = 1'b1;
    for (int n = 0; n < 400; n++) begin
      @(negedge clk);
      bus.Start = 1'b0;
      if (n == 399) rstn = 1'b0;
    end
    @(negedge clk);
    n_cmp++;
    if (bus.SRAM_address !== 18'd0 || bus.SRAM_write_data !== 16'd0 ||
        bus.SRAM_we_n !== 1'b1 || bus.Busy !== 1'b0 ||
        bus.Done !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_rst: addr=%h wd=%h we_n=%b busy=%b done=%b, required 0 0 1 0 0",
               bus.SRAM_address, bus.SRAM_write_data, bus.SRAM_we_n,
               bus.Busy, bus.Done);
    end
    rstn = 1'b1;
    bad = 0;
    for (int n = 0; n < 700; n++) begin
      @(negedge clk);
      if (bus.Done !== 1'b0 || bus.SRAM_we_n !== 1'b1 ||
          bus.Busy !== 1'b0) bad++;
    end
    n_cmp++;
    if (bad !== 0) begin
      n_bad++;
      $display("FAIL mid_quiet: %0d active cycles after abort, required 0", bad);
    end
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 255));
    run_block(18'h05400, 18'h1A000, 1'b0, 640);
    check_counts("post_rst");
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 64; i++) blk[i] = 255;
    run_block(18'h06400, 18'h1C000, 1'b0, 611);
    check_counts("b2b_a");
    for (int i = 0; i < 64; i++) blk[i] = int'($urandom_range(0, 255));
    run_block(18'h07400, 18'h1E000, 1'b0, 640);
    check_counts("b2b_b");
  endtask

  initial begin
    bus.Start         = 1'b0;
    bus.Pixel_address = 18'd0;
    bus.Coeff_address = 18'd0;
    clear_mem();
    test_reset();
    test_zero();
    test_const128();
    test_impulse();
    test_restart();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fdct_block_encoder.md
# fdct_block_encoder

Forward-DCT block encoder: the compression-side counterpart of the Milestone 2 IDCT decoder. It reads one 8x8 block of 8-bit pixels from SRAM (two pixels per 16-bit word), computes S = C·P·Cᵀ with the same integer C matrix the decoder uses, and writes 64 signed 16-bit coefficients back to the pre-IDCT coefficient region. It is driven block-by-block by a top-level sequencer via Start/Done and owns the SRAM port only while Busy is high.

## Interface
- PIXEL_STRIDE, 18'd160: words between successive pixel rows (80 for U/V).
- COEFF_STRIDE, 18'd320: words between successive coefficient rows (160 for U/V).
- Clock  in  1  single clock; all state updates on rising edge.
- Resetn  in  1  reset is synchronous and active-low.
- Start  in  1  one-cycle request; sampled only in IDLE.
- Pixel_address  in  18  word address of block top-left pixel pair; latched on accepted Start.
- Coeff_address  in  18  word address of coefficient S[0][0]; latched on accepted Start.
- SRAM_address  out  18  registered.
- SRAM_read_data  in  16  valid 2 cycles after the address is registered.
- SRAM_write_data  out  16  registered.
- SRAM_we_n  out  1  active-low write enable, registered.
- Busy  out  1  high from the edge after Start through the last write.
- Done  out  1  one-cycle pulse when the block is complete.

## Operation
- Reset values: SRAM_address 0, SRAM_write_data 0, SRAM_we_n 1, Busy 0, Done 0; FSM in IDLE.
- FSM: IDLE -> FETCH -> PASS_T -> PASS_S -> WRITE -> IDLE; no other transitions except reset.
- FETCH: 32 reads, row-major: address = Pixel_address + r·PIXEL_STRIDE + c, r 0..7, c 0..3; word {[15:8],[7:0]} = {P[r][2c], P[r][2c+1]}; stored in 64x8 pixel array.
- PASS_T: T[r][k] = Σj P[r][j]·C[k][j]; 32-bit signed accumulate; stored as (acc >>> 8)[15:0] in a 64x16 array.
- PASS_S: S[k][m] = Σr C[k][r]·T[r][m]; 32-bit signed accumulate; result (acc >>> 16)[15:0].
- C values: signed, scale 4096 (1448, 2008, 1892, 1702, 1448, 1137, 783, 399 magnitudes), identical to decoder.
- Two multipliers; 2 products per cycle; 4 cycles per output entry; entries row-major.
- WRITE: 64 writes, SRAM_we_n 0, address = Coeff_address + k·COEFF_STRIDE + m, row-major.
- SRAM_we_n is 1 in every state except WRITE.
- Start while Busy: ignored, no queueing. Start coincident with Done cycle: ignored (FSM in WRITE tail).
- Resetn low mid-operation: next edge returns to reset values; writes already issued stay in SRAM; no Done.

## Timing
- Edge 0 samples Start in IDLE.
- FETCH edges 1–34 (32 address issues + 2 latency), PASS_T 35–290, PASS_S 291–546, WRITE 547–610.
- Done high for exactly one cycle after edge 611; Busy falls at the same edge. Fixed latency 611 cycles, data-independent.
- Back-to-back: next Start accepted at edge 612 earliest.

## Configuration
- FDCT_LEVEL_SHIFT_EN defined: each pixel becomes signed (P − 128), 9-bit, before PASS_T.
- Not defined: pixels used as unsigned 0..255 zero-extended; no level shift.

## Structure
- Shared package: FSM state enum, C-matrix constant array, scale shifts (8, 16), default strides.
- One sub-module: fdct_c_rom (two read ports, index i,j -> signed C value), replacing per-block duplication.
- Pixel and T arrays as registers; no dual-port RAM needed.

## Test plan
- All-zero block, macro off -> 64 writes of 16'h0000 at Coeff_address + k·320 + m; Done at edge 611.
- Constant 128 block, macro off -> S[0][0]=1023, all other 63 coefficients 0.
- Constant 128 block, macro on -> all 64 coefficients 0.
- P[0][0]=255, rest 0, macro off -> S[0][0]=31; address/we_n sequence checked cycle-exact.
- Start pulsed again at edges 5 and 300 -> ignored; single Done; exactly 32 reads and 64 writes.
- Resetn low at edge 400 (PASS_S) -> outputs at reset values next edge, no Done, SRAM_we_n stays 1; new Start completes normally.
